// File: rtl/precision_dac_pkg.sv
// precision_dac_pkg: shared sizes, reset code, FSM encoding and packed-channel slice helper
package precision_dac_pkg;
  localparam int N_CH = 4;
  localparam int WIDTH = 16;
  localparam int PERIOD_W = 32;
  localparam int CH_W = $clog2(N_CH);
  localparam logic [WIDTH-1:0] RESET_CODE = 16'h8000;
  localparam logic [N_CH*WIDTH-1:0] RESET_WORD = {N_CH{RESET_CODE}};
  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;
  function automatic logic [WIDTH-1:0] slice(input logic [N_CH*WIDTH-1:0] w, input int i);
    return w[i*WIDTH +: WIDTH];
  endfunction
endpackage

// File: rtl/precision_dac_slew_step.sv
// precision_dac_slew_step: one channel slew step (cur, tgt, step) -> (nxt, moved); clamps at tgt, never wraps
module precision_dac_slew_step
  import precision_dac_pkg::*;
(
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] tgt,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] nxt,
  output logic             moved
);
  logic up;
  logic [WIDTH:0] d;
  always_comb begin
    up = tgt >= cur;
    d = up ? {1'b0, tgt} - {1'b0, cur} : {1'b0, cur} - {1'b0, tgt};
    nxt = (step == '0 || d <= {1'b0, step}) ? tgt : up ? cur + step : cur - step;
    moved = nxt != cur;
  end
endmodule

// File: rtl/precision_dac_slew.sv
// precision_dac_slew: per-tick slew limiter; clk/rst, target/target_valid/step/update_period in, data/valid/settled out
module precision_dac_slew
  import precision_dac_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] target,
  input  logic                  target_valid,
  input  logic [WIDTH-1:0]      step,
  input  logic [PERIOD_W-1:0]   update_period,
  output logic [N_CH*WIDTH-1:0] data,
  output logic                  valid,
  output logic                  settled
);
  state_t state, state_n;
  logic [PERIOD_W-1:0] cnt, reload;
  logic [N_CH*WIDTH-1:0] tgt_reg, tgt_snap, cur, cur_upd;
  logic [WIDTH-1:0] step_snap, nxt;
  logic [CH_W-1:0] ch;
  logic changed, moved, tick, last;
  precision_dac_slew_step u_step (
    .cur   (slice(cur, int'(ch))),
    .tgt   (slice(tgt_snap, int'(ch))),
    .step  (step_snap),
    .nxt   (nxt),
    .moved (moved)
  );
  always_comb begin
    tick = cnt == '0;
    reload = update_period == '0 ? '0 : update_period - 1'b1;
    last = state == SCAN && ch == CH_W'(N_CH - 1);
    cur_upd = cur;
    cur_upd[int'(ch)*WIDTH +: WIDTH] = nxt;
    state_n = (state == IDLE && tick) ? SCAN : last ? EMIT : state == EMIT ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ch <= '0;
      changed <= 1'b0;
      cur <= RESET_WORD;
      tgt_reg <= RESET_WORD;
      tgt_snap <= RESET_WORD;
      step_snap <= '0;
      data <= RESET_WORD;
      valid <= 1'b0;
      settled <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= tick ? reload : cnt - 1'b1;
      valid <= last && (changed || moved);
      settled <= data == (target_valid ? target : tgt_reg);
      if (target_valid) tgt_reg <= target;
      if (state == IDLE && tick) begin
        tgt_snap <= tgt_reg;
        step_snap <= step;
        changed <= 1'b0;
        ch <= '0;
      end
      if (state == SCAN) begin
        cur <= cur_upd;
        changed <= changed | moved;
        ch <= ch + 1'b1;
      end
      if (last && (changed || moved)) data <= cur_upd;
    end
  end
endmodule
